// File: rtl/riscv_clint_pkg.sv
// Shared constants and types for the CLINT-style machine timer block.
package riscv_clint_pkg;

  localparam int unsigned TIMER_W = 64;

  localparam logic [15:0] MSIP_OFF        = 16'h0000;
  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

  localparam logic [TIMER_W-1:0] MTIMECMP_RST = '1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_sel_e;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

endpackage

// File: rtl/clint_prescaler.sv
// Divides CLK down to a one-cycle TICK every TICK_DIV cycles.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign TICK = (cnt == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (TICK) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/machine_timer_irq.sv
// Memory-mapped mtime/mtimecmp/msip unit for a single hart, driving MTIP/MSIP.
module machine_timer_irq
  import riscv_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 1,
  parameter logic [15:0] BASE_MSIP     = MSIP_OFF,
  parameter logic [15:0] BASE_MTIMECMP = MTIMECMP_LO_OFF,
  parameter logic [15:0] BASE_MTIME    = MTIME_LO_OFF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                BUS_VALID,
  output logic                BUS_READY,
  input  logic                BUS_WRITE,
  input  logic [15:0]         BUS_ADDR,
  input  logic [31:0]         BUS_WDATA,
  output logic                BUS_RVALID,
  output logic [31:0]         BUS_RDATA,
  output logic                BUS_ERR,
  output logic                MTIP,
  output logic                MSIP,
  output logic [TIMER_W-1:0]  MTIME
);

  localparam logic [15:0] CMP_HI_ADDR  = BASE_MTIMECMP + 16'h4;
  localparam logic [15:0] TIME_HI_ADDR = BASE_MTIME + 16'h4;

  bus_state_e         state;
  reg_sel_e           sel;
  logic               tick;
  logic               acc;
  logic               wr;
  logic [TIMER_W-1:0] mtime, mtime_nxt;
  logic [TIMER_W-1:0] mtimecmp, cmp_nxt;
  logic               msip, msip_nxt;
  logic [31:0]        rdata_nxt;
  logic               err_nxt;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^BUS_ADDR[1:0];

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

  assign BUS_READY = (state == BUS_IDLE);
  assign MSIP      = msip;
  assign MTIME     = mtime;

  always_comb begin
    sel = REG_NONE;
    if      (BUS_ADDR[15:2] == BASE_MSIP[15:2])     sel = REG_MSIP;
    else if (BUS_ADDR[15:2] == BASE_MTIMECMP[15:2]) sel = REG_CMP_LO;
    else if (BUS_ADDR[15:2] == CMP_HI_ADDR[15:2])   sel = REG_CMP_HI;
    else if (BUS_ADDR[15:2] == BASE_MTIME[15:2])    sel = REG_TIME_LO;
    else if (BUS_ADDR[15:2] == TIME_HI_ADDR[15:2])  sel = REG_TIME_HI;
  end

  // A write to either mtime half overrides the tick increment entirely,
  // so no carry can leak into the half that was not written.
  always_comb begin
    acc       = BUS_VALID && BUS_READY;
    wr        = acc && BUS_WRITE;
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    cmp_nxt   = mtimecmp;
    msip_nxt  = msip;
    rdata_nxt = '0;
    err_nxt   = acc && (sel == REG_NONE);
    if (wr) begin
      case (sel)
        REG_MSIP:    msip_nxt  = BUS_WDATA[0];
        REG_CMP_LO:  cmp_nxt   = {mtimecmp[63:32], BUS_WDATA};
        REG_CMP_HI:  cmp_nxt   = {BUS_WDATA, mtimecmp[31:0]};
        REG_TIME_LO: mtime_nxt = {mtime[63:32], BUS_WDATA};
        REG_TIME_HI: mtime_nxt = {BUS_WDATA, mtime[31:0]};
        default:     ;
      endcase
    end else if (acc) begin
      case (sel)
        REG_MSIP:    rdata_nxt = {31'b0, msip};
        REG_CMP_LO:  rdata_nxt = mtimecmp[31:0];
        REG_CMP_HI:  rdata_nxt = mtimecmp[63:32];
        REG_TIME_LO: rdata_nxt = mtime[31:0];
        REG_TIME_HI: rdata_nxt = mtime[63:32];
        default:     rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= BUS_IDLE;
      mtime      <= '0;
      mtimecmp   <= MTIMECMP_RST;
      msip       <= 1'b0;
      BUS_RVALID <= 1'b0;
      BUS_RDATA  <= '0;
      BUS_ERR    <= 1'b0;
      MTIP       <= 1'b0;
    end else begin
      case (state)
        BUS_IDLE: state <= acc ? BUS_RESP : BUS_IDLE;
        BUS_RESP: state <= BUS_IDLE;
        default:  state <= BUS_IDLE;
      endcase
      mtime      <= mtime_nxt;
      mtimecmp   <= cmp_nxt;
      msip       <= msip_nxt;
      BUS_RVALID <= acc;
      BUS_RDATA  <= rdata_nxt;
      BUS_ERR    <= err_nxt;
      MTIP       <= (mtime_nxt >= cmp_nxt);
    end
  end

endmodule
